// File: rtl/idu_seq.sv
// Decode-stage sequencer: two-entry skid buffer between IFU and EXU that tags
// each held instruction with its immediate-format code and an illegal flag.
module idu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_itype,
    output logic            out_illegal,
    input  logic            flush,
    output logic [31:0]     decode_cnt
);

    localparam logic [2:0] NULL_TYPE = 3'd0;
    localparam logic [2:0] I_TYPE    = 3'd1;
    localparam logic [2:0] U_TYPE    = 3'd2;
    localparam logic [2:0] J_TYPE    = 3'd3;
    localparam logic [2:0] S_TYPE    = 3'd4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HEAD  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   head_inst_q, head_inst_d, head_pc_q, head_pc_d;
    logic [2:0]        head_itype_q, head_itype_d;
    logic              head_ill_q, head_ill_d;
    logic [XLEN-1:0]   skid_inst_q, skid_inst_d, skid_pc_q, skid_pc_d;
    logic [2:0]        skid_itype_q, skid_itype_d;
    logic              skid_ill_q, skid_ill_d;
    logic [31:0]       cnt_q, cnt_d;

    logic [2:0]        in_itype;
    logic              in_ill;
    logic              accept, fire;

    // Classification happens once, at write time, so the outputs are pure flops.
    always_comb begin
        in_itype = NULL_TYPE;
        in_ill   = 1'b0;
        case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: in_itype = I_TYPE;
            7'b0110111, 7'b0010111:                         in_itype = U_TYPE;
            7'b1101111:                                     in_itype = J_TYPE;
            7'b0100011:                                     in_itype = S_TYPE;
            7'b0110011, 7'b1100011:                         in_itype = NULL_TYPE;
            default:                                        in_ill   = 1'b1;
        endcase
    end

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        head_inst_d  = head_inst_q;
        head_pc_d    = head_pc_q;
        head_itype_d = head_itype_q;
        head_ill_d   = head_ill_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        skid_itype_d = skid_itype_q;
        skid_ill_d   = skid_ill_q;
        cnt_d        = cnt_q + {31'd0, fire};

        if (flush) begin
            // Held data is left in place; only occupancy is dropped.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = HEAD;
                        head_inst_d  = in_inst;
                        head_pc_d    = in_pc;
                        head_itype_d = in_itype;
                        head_ill_d   = in_ill;
                    end
                end
                HEAD: begin
                    if (accept && fire) begin
                        head_inst_d  = in_inst;
                        head_pc_d    = in_pc;
                        head_itype_d = in_itype;
                        head_ill_d   = in_ill;
                    end else if (accept) begin
                        state_d      = FULL;
                        skid_inst_d  = in_inst;
                        skid_pc_d    = in_pc;
                        skid_itype_d = in_itype;
                        skid_ill_d   = in_ill;
                    end else if (fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (fire) begin
                        state_d      = HEAD;
                        head_inst_d  = skid_inst_q;
                        head_pc_d    = skid_pc_q;
                        head_itype_d = skid_itype_q;
                        head_ill_d   = skid_ill_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            head_inst_q  <= '0;
            head_pc_q    <= '0;
            head_itype_q <= NULL_TYPE;
            head_ill_q   <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
            skid_itype_q <= NULL_TYPE;
            skid_ill_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            head_inst_q  <= head_inst_d;
            head_pc_q    <= head_pc_d;
            head_itype_q <= head_itype_d;
            head_ill_q   <= head_ill_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            skid_itype_q <= skid_itype_d;
            skid_ill_q   <= skid_ill_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_inst    = head_inst_q;
    assign out_pc      = head_pc_q;
    assign out_itype   = head_itype_q;
    assign out_illegal = head_ill_q;
    assign decode_cnt  = cnt_q;

endmodule
